proc_feeder: RTL and testbench

- Instruction-issue sequencer that drives the processor's instruction side: Run, DIN, and the consumption of Done.
- Fetches 16-bit words from a synchronous program ROM at a program counter.
- Presents each instruction to the processor with a one-cycle Run pulse, supplies the immediate word on the following cycle for MVI, then waits for Done before fetching the next instruction.
- Sits between the program ROM and the processor at the top level; replaces the manual switch/pushbutton feed.

---
 rtl/proc_feeder.sv | 173 +++++++++++++++++
 tb/tb_proc_feeder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/proc_feeder.sv
// rtl/proc_feeder.sv - instruction-issue sequencer between program ROM and processor
//
// Purpose:
//   Fetches 16-bit words from a synchronous program ROM and feeds them to the
//   processor. Each instruction is announced with a one-cycle Run pulse. For
//   MVI the immediate word follows on DIN in the next cycle. The sequencer then
//   waits for Done before fetching the next instruction. HALT_WORD stops issue.
//   A missing Done raises a sticky Error and halts.
//
// Ports:
//   Clock    in   1       system clock, rising edge
//   Resetn   in   1       asynchronous active-low reset
//   Go       in   1       start/restart request, sampled in IDLE and HALTED only
//   MemAddr  out  ADDR_W  ROM address; ROM returns MemQ one cycle later
//   MemQ     in   16      ROM read data
//   DIN      out  16      instruction or immediate word to the processor
//   Run      out  1       one-cycle pulse marking the instruction cycle on DIN
//   Done     in   1       processor completion, honoured in DATA and WAIT_DONE
//   Halted   out  1       high while halted
//   Error    out  1       sticky Done-timeout flag, cleared by a restart
//   Retired  out  8       count of completed instructions, wraps at 255

module proc_feeder #(
  parameter int          ADDR_W    = 5,
  parameter int          TIMEOUT   = 8,
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Go,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic [15:0]       MemQ,
  output logic [15:0]       DIN,
  output logic              Run,
  input  logic              Done,
  output logic              Halted,
  output logic              Error,
  output logic [7:0]        Retired
);

  localparam logic [2:0]        OP_MVI   = 3'd1;
  localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_I,
    S_LATCH_I,
    S_LATCH_D,
    S_ISSUE,
    S_DATA,
    S_WAIT_DONE,
    S_HALTED
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       instr;
  logic [15:0]       imm;
  logic              is_mvi;
  logic [CNT_W-1:0]  cnt;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state   <= S_IDLE;
      pc      <= '0;
      instr   <= '0;
      imm     <= '0;
      is_mvi  <= 1'b0;
      cnt     <= '0;
      MemAddr <= '0;
      DIN     <= '0;
      Run     <= 1'b0;
      Halted  <= 1'b0;
      Error   <= 1'b0;
      Retired <= '0;
    end else begin
      // Run is high only for the single cycle spent in ISSUE.
      Run <= 1'b0;

      case (state)
        S_IDLE: begin
          if (Go) begin
            MemAddr <= pc;
            state   <= S_FETCH_I;
          end
        end

        S_FETCH_I: begin
          // The ROM captures the instruction address at the end of this
          // cycle, so the address of the following word can already be put
          // out for a possible MVI immediate fetch during LATCH_I.
          MemAddr <= pc + PC_ONE;
          state   <= S_LATCH_I;
        end

        S_LATCH_I: begin
          if (MemQ == HALT_WORD) begin
            Halted <= 1'b1;
            state  <= S_HALTED;
          end else begin
            instr  <= MemQ;
            pc     <= pc + PC_ONE;
            is_mvi <= (MemQ[8:6] == OP_MVI);
            if (MemQ[8:6] == OP_MVI) begin
              state <= S_LATCH_D;
            end else begin
              Run   <= 1'b1;
              DIN   <= MemQ;
              state <= S_ISSUE;
            end
          end
        end

        S_LATCH_D: begin
          // The immediate is data, never checked against HALT_WORD.
          imm   <= MemQ;
          pc    <= pc + PC_ONE;
          Run   <= 1'b1;
          DIN   <= instr;
          state <= S_ISSUE;
        end

        S_ISSUE: begin
          DIN   <= is_mvi ? imm : instr;
          cnt   <= '0;
          state <= S_DATA;
        end

        S_DATA: begin
          if (Done) begin
            Retired <= Retired + 8'd1;
            MemAddr <= pc;
            state   <= S_FETCH_I;
          end else begin
            state <= S_WAIT_DONE;
          end
        end

        S_WAIT_DONE: begin
          // Done is still honoured in the last counted cycle; the timeout
          // fires only when that cycle also passes without it.
          if (Done) begin
            Retired <= Retired + 8'd1;
            MemAddr <= pc;
            state   <= S_FETCH_I;
          end else if (cnt == CNT_LAST) begin
            Error  <= 1'b1;
            Halted <= 1'b1;
            state  <= S_HALTED;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        S_HALTED: begin
          if (Go) begin
            pc      <= '0;
            MemAddr <= '0;
            Error   <= 1'b0;
            Halted  <= 1'b0;
            state   <= S_FETCH_I;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_feeder.sv
// tb/tb_proc_feeder.sv - self-checking bench for proc_feeder with an instruction-level model

module tb_proc_feeder;

  localparam int ADDR_W  = 3;
  localparam int ROM_N   = 1 << ADDR_W;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              go;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_q;
  logic [15:0]       din;
  logic              run;
  logic              done;
  logic              halted;
  logic              error;
  logic [7:0]        retired;

  logic [15:0] rom [ROM_N];

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Reference model state: next instruction address and retired count.
  int m_pc;
  int m_retired;

  proc_feeder #(
    .ADDR_W   (ADDR_W),
    .TIMEOUT  (TIMEOUT),
    .HALT_WORD(16'hFFFF)
  ) dut (
    .Clock  (clk),
    .Resetn (rst_n),
    .Go     (go),
    .MemAddr(mem_addr),
    .MemQ   (mem_q),
    .DIN    (din),
    .Run    (run),
    .Done   (done),
    .Halted (halted),
    .Error  (error),
    .Retired(retired)
  );

  always #5 clk = ~clk;

  // Synchronous program ROM.
  always @(posedge clk) mem_q <= rom[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while the DUT is fetching the instruction at m_pc.
  // k = number of waiting cycles after DATA before Done; k > TIMEOUT never answers.
  task automatic exec_one(input int k);
    logic [15:0] w;
    logic [15:0] exp_data;
    bit          mvi;
    int          lat;
    w = rom[m_pc];
    chk("fetch_addr", mem_addr, m_pc);
    if (w == 16'hFFFF) begin
      @(negedge clk);
      @(negedge clk);
      chk("halt_halted", halted, 1);
      chk("halt_retired", retired, m_retired[7:0]);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("halt_no_run", run, 0);
      end
      return;
    end
    mvi      = (w[8:6] == 3'd1);
    exp_data = mvi ? rom[(m_pc + 1) % ROM_N] : w;
    lat = 0;
    while (run !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
      go = 1'($urandom_range(0, 1));
    end
    chk("issue_latency", lat, mvi ? 3 : 2);
    chk("issue_din", din, w);
    @(negedge clk);
    chk("data_run_low", run, 0);
    chk("data_din", din, exp_data);
    done = (k == 0);
    for (int i = 1; i <= k && i <= TIMEOUT; i++) begin
      @(negedge clk);
      go   = 1'($urandom_range(0, 1));
      done = (i == k);
      chk("wait_run_low", run, 0);
      chk("wait_din", din, exp_data);
    end
    @(negedge clk);
    done = 1'b0;
    go   = 1'b0;
    if (k <= TIMEOUT) begin
      m_retired++;
      m_pc = (m_pc + (mvi ? 2 : 1)) % ROM_N;
      chk("retired", retired, m_retired[7:0]);
      chk("not_halted", halted, 0);
    end else begin
      chk("timeout_error", error, 1);
      chk("timeout_halted", halted, 1);
      chk("timeout_retired", retired, m_retired[7:0]);
    end
  endtask

  // Called at a negedge in IDLE or HALTED; leaves the DUT fetching from address 0.
  task automatic start();
    go = 1'b1;
    @(negedge clk);
    go   = 1'b0;
    m_pc = 0;
    chk("start_halted", halted, 0);
    chk("start_error", error, 0);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0;
    go    = 1'b0;
    done  = 1'b0;
    for (int i = 0; i < ROM_N; i++) rom[i] = 16'h0000;
    m_pc      = 0;
    m_retired = 0;
    repeat (2) @(negedge clk);
    chk("rst_run", run, 0);
    chk("rst_din", din, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_halted", halted, 0);
    chk("rst_error", error, 0);
    chk("rst_retired", retired, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Three single-word instructions then a halt.
    rom[0] = 16'h0008;
    rom[1] = 16'h0080;
    rom[2] = 16'h0010;
    rom[3] = 16'hFFFF;
    start();
    exec_one(0);
    exec_one(3);
    exec_one(int'($urandom_range(0, TIMEOUT)));
    exec_one(0);

    // MVI with immediate, then ADD, then halt.
    rom[0] = 16'h0040;
    rom[1] = 16'h1234;
    rom[2] = 16'h0080;
    rom[3] = 16'hFFFF;
    start();
    exec_one(0);
    exec_one(2);
    exec_one(0);

    // Done never arrives.
    start();
    exec_one(TIMEOUT + 5);
    start();
    chk("restart_addr", mem_addr, 0);

    // Immediate fetch wrapping from the last address to 0.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    m_retired = 0;
    for (int i = 0; i < ROM_N; i++) rom[i] = 16'($urandom) & 16'hFE3F;
    rom[ROM_N-1] = 16'h0040;
    @(negedge clk);
    start();
    for (int i = 0; i < ROM_N; i++) exec_one(int'($urandom_range(0, 2)));
    chk("wrap_pc", mem_addr, 1);

    // Random program with random Done timing.
    for (int i = 0; i < ROM_N; i++) begin
      rom[i] = 16'($urandom);
      if (rom[i] == 16'hFFFF) rom[i] = 16'h0041;
    end
    for (int n = 0; n < 30; n++) exec_one(int'($urandom_range(0, TIMEOUT)));

    // Reset asserted while waiting for Done.
    lat = 0;
    while (run !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk("pre_reset_run", run, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_run", run, 0);
    chk("async_din", din, 0);
    chk("async_addr", mem_addr, 0);
    chk("async_retired", retired, 0);
    chk("async_halted", halted, 0);
    chk("async_error", error, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    m_retired = 0;
    @(negedge clk);
    start();
    exec_one(1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
